// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor issue arbiter.
//   ADDR_W_DEF / CMD_W_DEF : default operand-address and ALU-command widths
//   CMD_NOP / NOP_ADDR     : command and address driven in an empty issue slot
//   coproc_instr_t         : one queued instruction {cmd, op0, op1}
//   trk_entry_t            : one in-flight tracker stage {valid, src, addr}
package coproc_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int CMD_W_DEF  = 3;

  localparam logic [CMD_W_DEF-1:0]  CMD_NOP  = 3'b111;
  // Register 0 is the scratch destination that NOP slots write.
  localparam logic [ADDR_W_DEF-1:0] NOP_ADDR = '0;

  typedef struct packed {
    logic [CMD_W_DEF-1:0]  cmd;
    logic [ADDR_W_DEF-1:0] op0;
    logic [ADDR_W_DEF-1:0] op1;
  } coproc_instr_t;

  typedef struct packed {
    logic                  valid;
    logic                  src;
    logic [ADDR_W_DEF-1:0] addr;
  } trk_entry_t;

endpackage

// File: rtl/coproc_req_fifo.sv
// Per-requester instruction FIFO.
//   clk, reset  : clock, synchronous active-high reset (clears pointers/count)
//   push, din   : write request and instruction; ignored while full
//   pop         : read request; ignored while empty
//   head        : oldest stored instruction (valid when !empty)
//   full, empty : derived from the occupancy count only
// DEPTH must be a power of two so the pointers wrap naturally.
module coproc_req_fifo
  import coproc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  coproc_instr_t din,
  input  logic          pop,
  output coproc_instr_t head,
  output logic          full,
  output logic          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  coproc_instr_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/coproc_issue_arb.sv
// Round-robin issue arbiter in front of the shared coprocessor pipeline.
//   clk, reset            : clock, synchronous active-high reset
//   reqN_valid/ready      : per-requester handshake (ready = FIFO not full)
//   reqN_cmd/op0/op1      : instruction fields offered by requester N
//   iss_cmd/op0/op1/valid : registered issue slot (NOP when iss_valid=0)
//   done_valid/src/addr   : registered writeback report, LAT cycles after issue
//   busy                  : anything queued, issued or still in flight
// Optional build macro COPROC_ARB_HAZARD_STALL_EN: hold a head whose op0
// matches the destination of an instruction that has not yet written back.
// ADDR_W/CMD_W must stay equal to the package defaults, which size the
// shared instruction and tracker types.
module coproc_issue_arb
  import coproc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CMD_W  = CMD_W_DEF,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CMD_W-1:0]  req0_cmd,
  input  logic [ADDR_W-1:0] req0_op0,
  input  logic [ADDR_W-1:0] req0_op1,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CMD_W-1:0]  req1_cmd,
  input  logic [ADDR_W-1:0] req1_op0,
  input  logic [ADDR_W-1:0] req1_op1,
  output logic [CMD_W-1:0]  iss_cmd,
  output logic [ADDR_W-1:0] iss_op0,
  output logic [ADDR_W-1:0] iss_op1,
  output logic              iss_valid,
  output logic              done_valid,
  output logic              done_src,
  output logic [ADDR_W-1:0] done_addr,
  output logic              busy
);

  coproc_instr_t din0, din1, head0, head1, gnt_instr;
  logic          full0, full1, empty0, empty1;
  logic          pop0, pop1;
  logic          elig0, elig1;
  logic          gnt_any, gnt_src;
  logic          last_src;
  logic          iss_src;
  trk_entry_t    trk_stage0;
  // Tracker stages 1..LAT-1; stage 0 is the issue register itself.
  trk_entry_t    trk_p [LAT-1];

  assign din0 = '{cmd: req0_cmd, op0: req0_op0, op1: req0_op1};
  assign din1 = '{cmd: req1_cmd, op0: req1_op0, op1: req1_op1};

  assign req0_ready = !full0;
  assign req1_ready = !full1;

  coproc_req_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (req0_valid),
    .din   (din0),
    .pop   (pop0),
    .head  (head0),
    .full  (full0),
    .empty (empty0)
  );

  coproc_req_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (req1_valid),
    .din   (din1),
    .pop   (pop1),
    .head  (head1),
    .full  (full1),
    .empty (empty1)
  );

  assign trk_stage0 = '{valid: iss_valid, src: iss_src, addr: iss_op1};

`ifdef COPROC_ARB_HAZARD_STALL_EN
  // op0 has no forwarding path: a head reading a register still being
  // produced (stages 0..LAT-2) waits; stage LAT-1 writes back as it issues.
  logic haz0, haz1;
  always_comb begin
    haz0 = trk_stage0.valid && (trk_stage0.addr == head0.op0);
    haz1 = trk_stage0.valid && (trk_stage0.addr == head1.op0);
    for (int k = 0; k < LAT-2; k++) begin
      haz0 = haz0 | (trk_p[k].valid && (trk_p[k].addr == head0.op0));
      haz1 = haz1 | (trk_p[k].valid && (trk_p[k].addr == head1.op0));
    end
  end
  assign elig0 = !empty0 && !haz0;
  assign elig1 = !empty1 && !haz1;
`else
  assign elig0 = !empty0;
  assign elig1 = !empty1;
`endif

  // Contention goes to the requester that did not win last time.
  always_comb begin
    gnt_any = elig0 | elig1;
    gnt_src = 1'b0;
    if (elig0 && elig1) gnt_src = ~last_src;
    else if (elig1)     gnt_src = 1'b1;
  end

  assign gnt_instr = gnt_src ? head1 : head0;
  assign pop0      = gnt_any && !gnt_src;
  assign pop1      = gnt_any &&  gnt_src;

  // ---- issue slot (tracker stage 0) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_src   <= 1'b0;
      iss_cmd   <= CMD_NOP;
      iss_op0   <= NOP_ADDR;
      iss_op1   <= NOP_ADDR;
      last_src  <= 1'b1;
    end else if (gnt_any) begin
      iss_valid <= 1'b1;
      iss_src   <= gnt_src;
      iss_cmd   <= gnt_instr.cmd;
      iss_op0   <= gnt_instr.op0;
      iss_op1   <= gnt_instr.op1;
      last_src  <= gnt_src;
    end else begin
      iss_valid <= 1'b0;
      iss_src   <= 1'b0;
      iss_cmd   <= CMD_NOP;
      iss_op0   <= NOP_ADDR;
      iss_op1   <= NOP_ADDR;
    end
  end

  // ---- tracker stages 1..LAT-1 and writeback report ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT-1; k++) trk_p[k] <= '0;
      done_valid <= 1'b0;
      done_src   <= 1'b0;
      done_addr  <= '0;
    end else begin
      trk_p[0] <= trk_stage0;
      for (int k = 1; k < LAT-1; k++) trk_p[k] <= trk_p[k-1];
      done_valid <= trk_p[LAT-2].valid;
      done_src   <= trk_p[LAT-2].src;
      done_addr  <= trk_p[LAT-2].addr;
    end
  end

  // The done register counts as in flight so busy drops only after the
  // last writeback has been reported.
  always_comb begin
    busy = !empty0 || !empty1 || iss_valid || done_valid;
    for (int k = 0; k < LAT-1; k++) busy = busy | trk_p[k].valid;
  end

endmodule
